// File: rtl/core_sequencer.sv
// Boot/debug sequencer: loads a program into instruction memory, releases the core,
// and provides halt/step/resume/reload control. Optional breakpoint: CORE_SEQUENCER_BREAKPOINT_EN.
module core_sequencer #(
  parameter int IMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        resetn,
  // Program load: a beat transfers on a rising edge where load_valid && load_ready;
  // load_ready is high only in LOAD and the producer holds data until accepted.
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_resetn,
  output logic        pc_en,
  input  logic [31:0] pc,
  input  logic        halt_req,
  input  logic        resume_req,
  input  logic        step_req,
  input  logic        reload_req,
  input  logic [31:0] bp_addr,
  input  logic        bp_enable,
  output logic [2:0]  state,
  output logic [31:0] retired,
  output logic        bp_hit
);

  localparam int AW = $clog2(IMEM_WORDS);
  localparam logic [AW-1:0] LAST_IDX = AW'(IMEM_WORDS - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] RUN   = 3'd3;
  localparam logic [2:0] HALT  = 3'd4;
  localparam logic [2:0] STEP  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] word_idx_q, word_idx_d;
  logic          load_ready_q, load_ready_d;
  logic          imem_we_q, imem_we_d;
  logic [31:0]   imem_addr_q, imem_addr_d;
  logic [31:0]   imem_wdata_q, imem_wdata_d;
  logic          core_resetn_q, core_resetn_d;
  logic          pc_en_q, pc_en_d;
  logic [31:0]   retired_q, retired_d;
  logic          bp_hit_q, bp_hit_d;
  logic          beat;
  logic          bp_match;

`ifdef CORE_SEQUENCER_BREAKPOINT_EN
  assign bp_match = bp_enable && (pc == bp_addr);
`else
  logic unused_bp;
  assign unused_bp = ^{pc, bp_addr, bp_enable};
  assign bp_match  = 1'b0;
`endif

  assign beat = load_valid && load_ready_q;

  always_comb begin
    state_d      = state_q;
    word_idx_d   = word_idx_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    retired_d    = retired_q + 32'(pc_en_q);
    bp_hit_d     = bp_hit_q;
    case (state_q)
      IDLE: state_d = LOAD;
      LOAD: begin
        if (beat) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = {{(30-AW){1'b0}}, word_idx_q, 2'b00};
          imem_wdata_d = load_data;
          word_idx_d   = word_idx_q + AW'(1);
          // The beat into the last word ends loading even without load_last.
          if (load_last || (word_idx_q == LAST_IDX)) state_d = START;
        end
      end
      START: state_d = RUN;
      RUN: begin
        if (halt_req || bp_match) state_d = HALT;
        if (bp_match) bp_hit_d = 1'b1;
      end
      HALT: begin
        if (reload_req) begin
          state_d    = LOAD;
          word_idx_d = '0;
          retired_d  = '0;
          bp_hit_d   = 1'b0;
        end else if (resume_req) begin
          state_d  = RUN;
          bp_hit_d = 1'b0;
        end else if (step_req) begin
          state_d  = STEP;
          bp_hit_d = 1'b0;
        end
      end
      STEP: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Registered control outputs follow the state being entered.
  always_comb begin
    load_ready_d  = (state_d == LOAD);
    core_resetn_d = (state_d == RUN) || (state_d == HALT) || (state_d == STEP);
    pc_en_d       = (state_d == RUN) || (state_d == STEP);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= IDLE;
      word_idx_q    <= '0;
      load_ready_q  <= 1'b0;
      imem_we_q     <= 1'b0;
      imem_addr_q   <= '0;
      imem_wdata_q  <= '0;
      core_resetn_q <= 1'b0;
      pc_en_q       <= 1'b0;
      retired_q     <= '0;
      bp_hit_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_idx_q    <= word_idx_d;
      load_ready_q  <= load_ready_d;
      imem_we_q     <= imem_we_d;
      imem_addr_q   <= imem_addr_d;
      imem_wdata_q  <= imem_wdata_d;
      core_resetn_q <= core_resetn_d;
      pc_en_q       <= pc_en_d;
      retired_q     <= retired_d;
      bp_hit_q      <= bp_hit_d;
    end
  end

  assign state       = state_q;
  assign load_ready  = load_ready_q;
  assign imem_we     = imem_we_q;
  assign imem_addr   = imem_addr_q;
  assign imem_wdata  = imem_wdata_q;
  assign core_resetn = core_resetn_q;
  assign pc_en       = pc_en_q;
  assign retired     = retired_q;
  assign bp_hit      = bp_hit_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: default-depth instance plus a 4-word instance for truncation.
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        resetn, load_valid, load_last;
  logic [31:0] load_data, pc, bp_addr;
  logic        halt_req, resume_req, step_req, reload_req, bp_enable;
  logic        load_ready, imem_we, core_resetn, pc_en, bp_hit;
  logic [31:0] imem_addr, imem_wdata, retired;
  logic [2:0]  state;

  logic        resetn4, load_valid4;
  logic        load_ready4, imem_we4, core_resetn4, pc_en4, bp_hit4;
  logic [31:0] imem_addr4, imem_wdata4, retired4;
  logic [2:0]  state4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  core_sequencer dut (
    .clk(clk), .resetn(resetn),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_resetn(core_resetn), .pc_en(pc_en),
    .pc(pc), .halt_req(halt_req), .resume_req(resume_req), .step_req(step_req),
    .reload_req(reload_req), .bp_addr(bp_addr), .bp_enable(bp_enable),
    .state(state), .retired(retired), .bp_hit(bp_hit)
  );

  core_sequencer #(.IMEM_WORDS(4)) dut4 (
    .clk(clk), .resetn(resetn4),
    .load_valid(load_valid4), .load_data(load_data), .load_last(load_last), .load_ready(load_ready4),
    .imem_we(imem_we4), .imem_addr(imem_addr4), .imem_wdata(imem_wdata4),
    .core_resetn(core_resetn4), .pc_en(pc_en4),
    .pc(pc), .halt_req(halt_req), .resume_req(resume_req), .step_req(step_req),
    .reload_req(reload_req), .bp_addr(bp_addr), .bp_enable(bp_enable),
    .state(state4), .retired(retired4), .bp_hit(bp_hit4)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic bring_up();
    do_reset();
    tick();
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1;
      load_data  = 32'h13 + 32'(i);
      load_last  = (i == 3);
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    resetn4 = 1'b0;
    tick();
    tick();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL reset_load_ready got=%b exp=0", load_ready); end
    checks++; if (imem_we !== 1'b0) begin failures++; $display("FAIL reset_imem_we got=%b exp=0", imem_we); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_imem_addr got=%h exp=0", imem_addr); end
    checks++; if (imem_wdata !== 32'h0) begin failures++; $display("FAIL reset_imem_wdata got=%h exp=0", imem_wdata); end
    checks++; if (core_resetn !== 1'b0) begin failures++; $display("FAIL reset_core_resetn got=%b exp=0", core_resetn); end
    checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL reset_pc_en got=%b exp=0", pc_en); end
    checks++; if (retired !== 32'h0) begin failures++; $display("FAIL reset_retired got=%0d exp=0", retired); end
    checks++; if (bp_hit !== 1'b0) begin failures++; $display("FAIL reset_bp_hit got=%b exp=0", bp_hit); end
    checks++; if (state4 !== 3'd0) begin failures++; $display("FAIL reset_state4 got=%0d exp=0", state4); end
  endtask

  task automatic test_load();
    logic [31:0] exp_data;
    resetn = 1'b1;
    tick();
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL load_enter_state got=%0d exp=1", state); end
    checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL load_ready got=%b exp=1", load_ready); end
    tick();
    checks++; if (imem_we !== 1'b0) begin failures++; $display("FAIL load_no_beat_we got=%b exp=0", imem_we); end
    for (int i = 0; i < 4; i++) begin
      exp_data   = (i == 3) ? 32'h0010_0093 : 32'h0000_0013;
      load_valid = 1'b1;
      load_data  = exp_data;
      load_last  = (i == 3);
      tick();
      checks++; if (imem_we !== 1'b1) begin failures++; $display("FAIL load_we[%0d] got=%b exp=1", i, imem_we); end
      checks++; if (imem_addr !== 32'(i * 4)) begin failures++; $display("FAIL load_addr[%0d] got=%h exp=%h", i, imem_addr, 32'(i * 4)); end
      checks++; if (imem_wdata !== exp_data) begin failures++; $display("FAIL load_wdata[%0d] got=%h exp=%h", i, imem_wdata, exp_data); end
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL load_start_state got=%0d exp=2", state); end
    checks++; if (core_resetn !== 1'b0 || pc_en !== 1'b0 || load_ready !== 1'b0) begin
      failures++; $display("FAIL load_start_ctrl got=%b%b%b exp=000", core_resetn, pc_en, load_ready); end
    tick();
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL load_run_state got=%0d exp=3", state); end
    checks++; if (core_resetn !== 1'b1 || pc_en !== 1'b1) begin
      failures++; $display("FAIL load_run_ctrl got=%b%b exp=11", core_resetn, pc_en); end
    checks++; if (imem_we !== 1'b0) begin failures++; $display("FAIL load_run_we got=%b exp=0", imem_we); end
  endtask

  task automatic test_halt_step();
    for (int i = 0; i < 9; i++) begin
      step_req   = (i == 4);
      resume_req = (i == 5);
      tick();
    end
    step_req = 1'b0;
    resume_req = 1'b0;
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL run_ignores_step got=%0d exp=3", state); end
    checks++; if (retired !== 32'd9) begin failures++; $display("FAIL run_retired9 got=%0d exp=9", retired); end
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    checks++; if (state !== 3'd4) begin failures++; $display("FAIL halt_state got=%0d exp=4", state); end
    checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL halt_pc_en got=%b exp=0", pc_en); end
    checks++; if (retired !== 32'd10) begin failures++; $display("FAIL halt_retired got=%0d exp=10", retired); end
    for (int i = 0; i < 3; i++) begin
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      checks++; if (state !== 3'd5 || pc_en !== 1'b1) begin
        failures++; $display("FAIL step_pulse[%0d] got=state%0d pc_en%b exp=state5 pc_en1", i, state, pc_en); end
      tick();
      checks++; if (state !== 3'd4 || pc_en !== 1'b0) begin
        failures++; $display("FAIL step_return[%0d] got=state%0d pc_en%b exp=state4 pc_en0", i, state, pc_en); end
    end
    checks++; if (retired !== 32'd13) begin failures++; $display("FAIL step_retired got=%0d exp=13", retired); end
  endtask

  task automatic test_resume_reload();
    resume_req = 1'b1;
    step_req   = 1'b1;
    tick();
    resume_req = 1'b0;
    step_req   = 1'b0;
    checks++; if (state !== 3'd3 || pc_en !== 1'b1) begin
      failures++; $display("FAIL resume_prio got=state%0d pc_en%b exp=state3 pc_en1", state, pc_en); end
    reload_req = 1'b1;
    tick();
    reload_req = 1'b0;
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL reload_in_run got=%0d exp=3", state); end
    checks++; if (retired !== 32'd14) begin failures++; $display("FAIL reload_in_run_retired got=%0d exp=14", retired); end
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    checks++; if (retired !== 32'd15) begin failures++; $display("FAIL halt2_retired got=%0d exp=15", retired); end
    reload_req = 1'b1;
    resume_req = 1'b1;
    tick();
    reload_req = 1'b0;
    resume_req = 1'b0;
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL reload_state got=%0d exp=1", state); end
    checks++; if (core_resetn !== 1'b0) begin failures++; $display("FAIL reload_core_resetn got=%b exp=0", core_resetn); end
    checks++; if (retired !== 32'd0) begin failures++; $display("FAIL reload_retired got=%0d exp=0", retired); end
    load_valid = 1'b1;
    load_data  = 32'hA5A5_0001;
    load_last  = 1'b1;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
    checks++; if (imem_we !== 1'b1 || imem_addr !== 32'h0) begin
      failures++; $display("FAIL reload_first_write got=we%b addr%h exp=we1 addr0", imem_we, imem_addr); end
    tick();
  endtask

  task automatic test_halt_at_start();
    do_reset();
    tick();
    load_valid = 1'b1;
    load_data  = 32'h0000_0013;
    load_last  = 1'b1;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
    halt_req   = 1'b1;
    tick();
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL start_halt_ignored got=%0d exp=3", state); end
    tick();
    halt_req = 1'b0;
    checks++; if (state !== 3'd4) begin failures++; $display("FAIL first_run_halt got=%0d exp=4", state); end
    checks++; if (retired !== 32'd1) begin failures++; $display("FAIL first_run_retired got=%0d exp=1", retired); end
  endtask

  task automatic test_breakpoint();
    bring_up();
    bp_enable = 1'b1;
    bp_addr   = 32'h0000_0008;
    pc = 32'h0;
    tick();
    pc = 32'h4;
    tick();
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL bp_early_state got=%0d exp=3", state); end
    pc = 32'h8;
    tick();
`ifdef CORE_SEQUENCER_BREAKPOINT_EN
    checks++; if (state !== 3'd4 || pc_en !== 1'b0) begin
      failures++; $display("FAIL bp_halt got=state%0d pc_en%b exp=state4 pc_en0", state, pc_en); end
    tick();
    tick();
    checks++; if (bp_hit !== 1'b1) begin failures++; $display("FAIL bp_hit_hold got=%b exp=1", bp_hit); end
    resume_req = 1'b1;
    pc = 32'hC;
    tick();
    resume_req = 1'b0;
    checks++; if (state !== 3'd3 || bp_hit !== 1'b0) begin
      failures++; $display("FAIL bp_resume got=state%0d bp_hit%b exp=state3 bp_hit0", state, bp_hit); end
`else
    tick();
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL bp_disabled_state got=%0d exp=3", state); end
    checks++; if (bp_hit !== 1'b0) begin failures++; $display("FAIL bp_disabled_hit got=%b exp=0", bp_hit); end
`endif
    bp_enable = 1'b0;
    pc = 32'h0;
  endtask

  task automatic test_overflow();
    int          writes;
    logic [31:0] last_addr;
    writes    = 0;
    last_addr = 32'hFFFF_FFFF;
    resetn4   = 1'b1;
    tick();
    load_last = 1'b0;
    for (int i = 0; i < 6; i++) begin
      load_valid4 = 1'b1;
      load_data   = 32'h100 + 32'(i);
      tick();
      if (imem_we4 === 1'b1) begin
        writes++;
        last_addr = imem_addr4;
      end
    end
    load_valid4 = 1'b0;
    checks++; if (writes !== 4) begin failures++; $display("FAIL ovf_writes got=%0d exp=4", writes); end
    checks++; if (last_addr !== 32'hC) begin failures++; $display("FAIL ovf_last_addr got=%h exp=c", last_addr); end
    checks++; if (load_ready4 !== 1'b0) begin failures++; $display("FAIL ovf_ready got=%b exp=0", load_ready4); end
    checks++; if (state4 !== 3'd3) begin failures++; $display("FAIL ovf_state got=%0d exp=3", state4); end
    resetn4 = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    tick();
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1;
      load_data  = 32'h11 * 32'(i + 1);
      tick();
    end
    load_valid = 1'b0;
    resetn = 1'b0;
    tick();
    checks++; if (state !== 3'd0 || load_ready !== 1'b0 || imem_we !== 1'b0) begin
      failures++; $display("FAIL midload_rst_ctrl got=state%0d rdy%b we%b exp=state0 rdy0 we0", state, load_ready, imem_we); end
    checks++; if (imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
      failures++; $display("FAIL midload_rst_bus got=addr%h data%h exp=0 0", imem_addr, imem_wdata); end
    checks++; if (core_resetn !== 1'b0 || pc_en !== 1'b0 || retired !== 32'h0 || bp_hit !== 1'b0) begin
      failures++; $display("FAIL midload_rst_core got=%b%b%0d%b exp=0000", core_resetn, pc_en, retired, bp_hit); end
    resetn = 1'b1;
    tick();
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL midload_reload_state got=%0d exp=1", state); end
    load_valid = 1'b1;
    load_data  = 32'h33;
    tick();
    load_valid = 1'b0;
    checks++; if (imem_we !== 1'b1 || imem_addr !== 32'h0 || imem_wdata !== 32'h33) begin
      failures++; $display("FAIL midload_restart got=we%b addr%h data%h exp=we1 addr0 data33", imem_we, imem_addr, imem_wdata); end
  endtask

  initial begin
    resetn = 1'b0; resetn4 = 1'b0;
    load_valid = 1'b0; load_valid4 = 1'b0; load_data = '0; load_last = 1'b0;
    halt_req = 1'b0; resume_req = 1'b0; step_req = 1'b0; reload_req = 1'b0;
    pc = '0; bp_addr = '0; bp_enable = 1'b0;
    test_reset();
    test_load();
    test_halt_step();
    test_resume_reload();
    test_halt_at_start();
    test_breakpoint();
    test_overflow();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 256, instruction-memory depth in 32-bit words (power of two, 2..65536).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port resetn  input  1  synchronous, active-low reset.
REQ-004 SHALL have ports load_valid input 1, load_data input 32, load_last input 1, and load_ready output 1, forming the program-load handshake.
REQ-005 SHALL have ports imem_we output 1, imem_addr output 32, and imem_wdata output 32, driving the instruction-memory write port.
REQ-006 SHALL have ports core_resetn output 1 (core reset, active-low) and pc_en output 1 (program-counter advance enable).
REQ-007 SHALL have ports pc input 32, halt_req input 1, resume_req input 1, step_req input 1, reload_req input 1, bp_addr input 32, and bp_enable input 1.
REQ-008 SHALL have ports state output 3, retired output 32, and bp_hit output 1.

Function
REQ-009 States and encodings SHALL be: IDLE=0, LOAD=1, START=2, RUN=3, HALT=4, STEP=5; the state output SHALL show the current state.
REQ-010 All outputs SHALL be registered; word_idx SHALL be an internal counter, 0..IMEM_WORDS-1.
REQ-011 IDLE SHALL go to LOAD on the next edge, unconditionally.
REQ-012 In LOAD, load_ready SHALL be 1; in every other state, load_ready SHALL be 0.
REQ-013 A LOAD beat is load_valid&&load_ready; on the same edge: imem_we<=1, imem_addr<=word_idx*4, imem_wdata<=load_data, word_idx increments.
REQ-014 On an edge with no beat, imem_we SHALL be 0; write latency from beat to imem_we high SHALL be exactly 1 cycle.
REQ-015 A beat with load_last=1 or word_idx==IMEM_WORDS-1 SHALL be final: next state START; further load_valid is ignored (overflow truncation).
REQ-016 START SHALL last exactly one cycle (final write completes); on exit: state RUN, core_resetn<=1, pc_en<=1.
REQ-017 core_resetn SHALL be 0 in IDLE, LOAD, and START, and 1 in RUN, HALT, and STEP.
REQ-018 RUN: pc_en SHALL be 1; halt_req=1 SHALL give HALT on the next edge with pc_en<=0; step_req and resume_req SHALL be ignored in RUN.
REQ-019 HALT: pc_en SHALL be 0; priority SHALL be reload_req > resume_req > step_req.
REQ-020 From HALT, resume_req SHALL give RUN with pc_en<=1; step_req SHALL give STEP.
REQ-021 STEP SHALL hold pc_en=1 for exactly one cycle, then return to HALT with pc_en<=0, whatever the request inputs are.
REQ-022 reload_req in HALT SHALL give LOAD with core_resetn<=0, word_idx<=0, retired<=0, and bp_hit<=0; reload_req in any other state SHALL be ignored.
REQ-023 retired SHALL increment by 1 on every edge where pc_en==1, wrapping 0xFFFFFFFF->0.
REQ-024 A halt_req in the same cycle as the START->RUN transition SHALL be ignored; it is honoured from the first RUN cycle.

Reset
REQ-025 resetn=0 at an edge SHALL set: state=IDLE, load_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_resetn=0, pc_en=0, retired=0, bp_hit=0, word_idx=0.
REQ-026 Reset mid-LOAD or mid-RUN SHALL abort immediately; all words written so far stay in memory, and loading restarts at word 0.

Configuration
REQ-027 Macro CORE_SEQUENCER_BREAKPOINT_EN defined SHALL enable the breakpoint: in RUN, if bp_enable && pc==bp_addr, the next edge gives HALT, pc_en<=0, bp_hit<=1.
REQ-028 In that HALT, bp_hit SHALL stay 1 until resume_req, step_req, or reload_req is accepted.
REQ-029 With the macro defined, a breakpoint match SHALL behave like halt_req; STEP SHALL ignore breakpoints.
REQ-030 Macro undefined SHALL keep bp_addr and bp_enable as ports but ignore them, and SHALL tie bp_hit to 0.

Verification
REQ-031 Load 4 beats (0x00000013 x3, then 0x00100093 with load_last): expect imem_we pulses at addr 0x0, 0x4, 0x8, 0xC, one START cycle, then core_resetn=1 and pc_en=1, state=3.
REQ-032 IMEM_WORDS=4, 6 beats offered without load_last: expect exactly 4 writes (last at addr 0xC), load_ready=0 afterwards, extra beats dropped.
REQ-033 RUN 10 cycles then halt_req: expect retired=10 (+/-0 per REQ-023 counting), state=4; then 3 step_req pulses give retired=13 and 3 single-cycle pc_en pulses.
REQ-034 In HALT, assert resume_req and step_req together: expect RUN; then assert reload_req in HALT: expect core_resetn=0, retired=0, state=1, next write at addr 0x0.
REQ-035 Macro defined, bp_enable=1, bp_addr=0x00000008, pc stepping 0,4,8: expect HALT the edge after pc==8, bp_hit=1 until resume_req.
REQ-036 Pull resetn low mid-LOAD after 2 beats: expect all outputs at REQ-025 values next edge, then the next beat written to addr 0x0.
